// File: rtl/axc_abs_diff_i8_o4_wc4_pkg.sv
// Shared widths, approximation defaults and the error-bound helper for the
// approximate absolute-difference unit.
package axc_abs_diff_i8_o4_wc4_pkg;

  localparam int unsigned OPW               = 4;
  localparam int unsigned INW               = 8;
  localparam int unsigned DROP_BITS_DEFAULT = 2;
  localparam int unsigned WC_DEFAULT        = 4;

  // True when a reported error stays within the guaranteed worst case.
  function automatic logic err_within_bound(input logic [OPW-1:0] e, input int unsigned wc);
    return (32'(e) <= wc);
  endfunction

endpackage

// File: rtl/axc_abs_diff_i8_o4_wc4_if.sv
// Sample/result bus for the approximate absolute-difference unit.
interface axc_abs_diff_i8_o4_wc4_if;
  import axc_abs_diff_i8_o4_wc4_pkg::*;

  logic           in_valid;
  logic [INW-1:0] pi;
  logic           out_valid;
  logic [OPW-1:0] po;
  logic [OPW-1:0] exact_po;
  logic [OPW-1:0] err;

  modport master (output in_valid, pi, input out_valid, po, exact_po, err);
  modport slave  (input in_valid, pi, output out_valid, po, exact_po, err);

endinterface

// File: rtl/axc_abs_diff_i8_o4_wc4_chk.sv
// Runtime check that the reported approximation error never exceeds WC.
module axc_abs_diff_i8_o4_wc4_chk
  import axc_abs_diff_i8_o4_wc4_pkg::*;
#(
  parameter int unsigned WC = WC_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  input logic           out_valid,
  input logic [OPW-1:0] err
);

  a_err_bound: assert property (@(posedge clk) disable iff (rst)
                                out_valid |-> err_within_bound(err, WC))
    else $error("approximation error %0d above bound %0d", err, WC);

endmodule

// File: rtl/axc_abs_diff_i8_o4_wc4_core.sv
// Combinational datapath: exact |a-b|, its truncated approximation and the
// resulting error, from the packed operand word.
module axc_abs_diff_i8_o4_wc4_core
  import axc_abs_diff_i8_o4_wc4_pkg::*;
#(
  parameter int unsigned DROP_BITS = DROP_BITS_DEFAULT
) (
  input  logic [INW-1:0] pi,
  output logic [OPW-1:0] exact,
  output logic [OPW-1:0] po,
  output logic [OPW-1:0] err
);

  localparam logic [OPW-1:0] KEEP_MASK = OPW'(~((32'd1 << DROP_BITS) - 32'd1));

  logic [OPW:0]   diff_s;
  logic [OPW-1:0] exact_s;
  logic [OPW-1:0] po_s;

  assign diff_s = {1'b0, pi[7:4]} - {1'b0, pi[3:0]};

  // Magnitude of the 5-bit signed difference; the low nibble alone is enough
  // to negate because the result always fits in 4 bits.
  always_comb begin
    exact_s = 4'd0;
    if (diff_s[OPW]) begin
      exact_s = 4'd0 - diff_s[OPW-1:0];
    end else begin
      exact_s = diff_s[OPW-1:0];
    end
  end

  assign po_s  = exact_s & KEEP_MASK;
  assign exact = exact_s;
  assign po    = po_s;
  assign err   = exact_s - po_s;

endmodule

// File: rtl/axc_abs_diff_i8_o4_wc4.sv
// Approximate absolute-difference unit: registered results with a one-cycle
// valid pipeline around the combinational core.
module axc_abs_diff_i8_o4_wc4
  import axc_abs_diff_i8_o4_wc4_pkg::*;
#(
  parameter int unsigned DROP_BITS = DROP_BITS_DEFAULT,
  parameter int unsigned WC        = WC_DEFAULT
) (
  input logic                     clk,
  input logic                     rst,
  axc_abs_diff_i8_o4_wc4_if.slave bus
);

  // Truncating DROP_BITS LSBs can lose up to 2^DROP_BITS-1, which must fit in WC.
  if (((32'd1 << DROP_BITS) - 32'd1) > WC) begin : g_bad_params
    $error("DROP_BITS=%0d cannot meet worst-case bound WC=%0d", DROP_BITS, WC);
  end

  logic [OPW-1:0] exact_s;
  logic [OPW-1:0] po_s;
  logic [OPW-1:0] err_s;

  logic           out_valid_r;
  logic [OPW-1:0] po_r;
  logic [OPW-1:0] exact_po_r;
  logic [OPW-1:0] err_r;

  axc_abs_diff_i8_o4_wc4_core #(
    .DROP_BITS (DROP_BITS)
  ) u_core (
    .pi    (bus.pi),
    .exact (exact_s),
    .po    (po_s),
    .err   (err_s)
  );

  // Output registers: results load only on valid samples and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      po_r        <= 4'd0;
      exact_po_r  <= 4'd0;
      err_r       <= 4'd0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        po_r       <= po_s;
        exact_po_r <= exact_s;
        err_r      <= err_s;
      end else begin
        po_r       <= po_r;
        exact_po_r <= exact_po_r;
        err_r      <= err_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.po        = po_r;
  assign bus.exact_po  = exact_po_r;
  assign bus.err       = err_r;

  axc_abs_diff_i8_o4_wc4_chk #(
    .WC (WC)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .out_valid (out_valid_r),
    .err       (err_r)
  );

endmodule

// File: tb/tb_axc_abs_diff_i8_o4_wc4.sv
// Directed bench for the approximate absolute-difference unit: reset, worked
// vectors, symmetry, hold behaviour, a full back-to-back sweep with a reset in it.
module tb_axc_abs_diff_i8_o4_wc4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  axc_abs_diff_i8_o4_wc4_if bus ();

  axc_abs_diff_i8_o4_wc4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Drive at a falling edge; return at the next falling edge, after the capture.
  task automatic drive(input logic r, input logic v, input logic [7:0] p);
    rst          = r;
    bus.in_valid = v;
    bus.pi       = p;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [3:0] ex,
                            input logic [3:0] ap, input logic [3:0] er);
    check({tag, ".valid"}, {3'b000, bus.out_valid}, {3'b000, v});
    check({tag, ".exact"}, bus.exact_po, ex);
    check({tag, ".po"},    bus.po,       ap);
    check({tag, ".err"},   bus.err,      er);
  endtask

  // Independent reference: magnitude by comparison, approximation by integer floor.
  task automatic expect_model(input string tag, input logic [7:0] p);
    int a, b, ex, ap;
    a  = int'(p[7:4]);
    b  = int'(p[3:0]);
    ex = (a > b) ? (a - b) : (b - a);
    ap = (ex / 4) * 4;
    expect_out(tag, 1'b1, 4'(ex), 4'(ap), 4'(ex - ap));
    check({tag, ".bound"}, {3'b000, (bus.err <= 4'd4)}, 4'd1);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.pi       = 8'hF0;
    @(negedge clk);

    drive(1'b1, 1'b1, 8'hF0);
    drive(1'b1, 1'b1, 8'hF0);
    expect_out("reset", 1'b0, 4'd0, 4'd0, 4'd0);

    drive(1'b0, 1'b1, 8'h00);
    expect_out("zero", 1'b1, 4'd0, 4'd0, 4'd0);
    drive(1'b0, 1'b1, 8'h13);
    expect_out("a1b3", 1'b1, 4'd2, 4'd0, 4'd2);
    drive(1'b0, 1'b1, 8'h31);
    expect_out("a3b1", 1'b1, 4'd2, 4'd0, 4'd2);
    drive(1'b0, 1'b1, 8'h5A);
    expect_out("a5b10", 1'b1, 4'd5, 4'd4, 4'd1);
    drive(1'b0, 1'b1, 8'hF0);
    expect_out("a15b0", 1'b1, 4'd15, 4'd12, 4'd3);
    drive(1'b0, 1'b1, 8'h0F);
    expect_out("a0b15", 1'b1, 4'd15, 4'd12, 4'd3);

    drive(1'b0, 1'b1, 8'h5A);
    expect_out("pre_idle", 1'b1, 4'd5, 4'd4, 4'd1);
    drive(1'b0, 1'b0, 8'hF0);
    expect_out("idle_hold", 1'b0, 4'd5, 4'd4, 4'd1);
    drive(1'b0, 1'b0, 8'h0F);
    expect_out("idle_hold2", 1'b0, 4'd5, 4'd4, 4'd1);

    for (int i = 0; i < 256; i++) begin
      if (i == 128) begin
        drive(1'b1, 1'b1, 8'hF0);
        expect_out("sweep_rst", 1'b0, 4'd0, 4'd0, 4'd0);
      end
      drive(1'b0, 1'b1, 8'(i));
      expect_model($sformatf("sweep%0d", i), 8'(i));
    end
    drive(1'b0, 1'b1, 8'h63);
    expect_out("a6b3", 1'b1, 4'd3, 4'd0, 4'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
